// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and single-cycle ALU function for alu_seq.
// The function works on ALU_MAX_W-bit operands and takes the real width as an argument.
package alu_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_ADDC = 3'b100;
    localparam logic [2:0] OP_SUBC = 3'b101;
    localparam logic [2:0] OP_CMP  = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    // Widest datapath the shared function supports.
    localparam int ALU_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } alu_state_t;

    typedef struct packed {
        logic                 carry;
        logic [ALU_MAX_W-1:0] res;
    } alu_res_t;

    // Operands must be zero-extended above bit w; only res[w-1:0] is meaningful.
    // Opcode 111 falls through to PASS here; the multiplier handles it when built.
    function automatic alu_res_t alu_calc(
        input logic [2:0]           op,
        input logic [ALU_MAX_W-1:0] a,
        input logic [ALU_MAX_W-1:0] b,
        input logic                 cflag,
        input logic [6:0]           w
    );
        logic [ALU_MAX_W:0] ea;
        logic [ALU_MAX_W:0] eb;
        logic [ALU_MAX_W:0] sum;
        logic [ALU_MAX_W:0] bin;
        alu_res_t           r;
        ea      = {1'b0, a};
        eb      = {1'b0, b};
        sum     = '0;
        bin     = '0;
        r.carry = cflag;
        r.res   = a;
        case (op)
            OP_AND: r.res = a & b;
            OP_OR:  r.res = a | b;
            OP_ADD, OP_ADDC: begin
                if (op == OP_ADDC) bin = {{ALU_MAX_W{1'b0}}, cflag};
                sum     = ea + eb + bin;
                r.res   = sum[ALU_MAX_W-1:0];
                r.carry = sum[w];
            end
            OP_SUB, OP_SUBC: begin
                // Carry flag is the inverted borrow: 1 means no borrow.
                if (op == OP_SUBC) bin = {{ALU_MAX_W{1'b0}}, ~cflag};
                sum     = ea - eb - bin;
                r.res   = sum[ALU_MAX_W-1:0];
                r.carry = (ea >= (eb + bin));
            end
            OP_CMP:  r.res = (a < b) ? {{(ALU_MAX_W-1){1'b0}}, 1'b1} : '0;
            default: r.res = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial-product step per cycle, WIDTH steps.
// done_o is asserted combinationally during the last step, with prod_o valid alongside it.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               done_o,
    output logic [2*WIDTH-1:0] prod_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    // {hi, lo} shifts right each step; multiplier bits leave lo as product bits enter.
    always_comb begin
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
        step_hi = sum[WIDTH:1];
        step_lo = {sum[0], lo_q[WIDTH-1:1]};
        done_o  = (cnt_q == CNT_W'(1));
        prod_o  = {step_hi, step_lo};
    end

    always_comb begin
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        if (start_i) begin
            mcand_d = a_i;
            hi_d    = '0;
            lo_d    = b_i;
            cnt_d   = CNT_W'(WIDTH);
        end else if (cnt_q != '0) begin
            hi_d  = step_hi;
            lo_d  = step_lo;
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
        end else begin
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered execute-unit ALU with valid/ready handshake and chained carry/zero flags.
// Define ALU_MUL_EN to make opcode 111 a multi-cycle MUL; otherwise it is PASS. WIDTH <= 64.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       CS,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] S_hi,
    output logic             zero,
    output logic             carry_out
);

    alu_state_t       state_q, state_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             accept;
    logic             mul_op;
    logic             mul_done;
    alu_res_t         res;
    logic [WIDTH-1:0] res_lo;

    assign accept = in_valid && in_ready;
    assign res    = alu_calc(CS, ALU_MAX_W'(data_a), ALU_MAX_W'(data_b), carry_q, 7'(WIDTH));
    assign res_lo = res.res[WIDTH-1:0];

    generate
        if (WIDTH < ALU_MAX_W) begin : g_res_hi
            logic unused_res_hi;
            assign unused_res_hi = ^res.res[ALU_MAX_W-1:WIDTH];
        end
    endgenerate

`ifdef ALU_MUL_EN
    logic [WIDTH-1:0]   s_hi_q, s_hi_d;
    logic [2*WIDTH-1:0] mul_prod;

    assign mul_op = (CS == OP_MUL);
    assign S_hi   = s_hi_q;

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (accept && mul_op),
        .a_i     (data_a),
        .b_i     (data_b),
        .done_o  (mul_done),
        .prod_o  (mul_prod)
    );
`else
    assign mul_op   = 1'b0;
    assign mul_done = 1'b0;
    assign S_hi     = '0;
`endif

    assign S         = s_q;
    assign zero      = zero_q;
    assign carry_out = carry_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d = mul_op ? MUL : DONE;
                end else if (state_q == DONE && out_ready) begin
                    state_d = IDLE;
                end
            end
            MUL:     if (mul_done) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state_q == DONE);
        in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
    end

    // Result and flags only move on a single-cycle accept or MUL completion.
    always_comb begin
        s_d     = s_q;
        zero_d  = zero_q;
        carry_d = carry_q;
`ifdef ALU_MUL_EN
        s_hi_d  = s_hi_q;
`endif
        if (accept && !mul_op) begin
            s_d     = res_lo;
            zero_d  = (res_lo == '0);
            carry_d = res.carry;
`ifdef ALU_MUL_EN
            s_hi_d  = '0;
`endif
        end
`ifdef ALU_MUL_EN
        if (mul_done) begin
            s_d     = mul_prod[WIDTH-1:0];
            s_hi_d  = mul_prod[2*WIDTH-1:WIDTH];
            zero_d  = (mul_prod == '0);
            carry_d = (mul_prod[2*WIDTH-1:WIDTH] != '0);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q     <= '0;
            zero_q  <= 1'b1;
            carry_q <= 1'b0;
`ifdef ALU_MUL_EN
            s_hi_q  <= '0;
`endif
        end else begin
            s_q     <= s_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
`ifdef ALU_MUL_EN
            s_hi_q  <= s_hi_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases plus random ops against an arithmetic model.
// Follows ALU_MUL_EN the same way as the design.
`timescale 1ns/1ps
module tb_alu_seq;

    localparam int W = 8;
    localparam int unsigned LIM = 1 << W;

    localparam logic [2:0] C_AND  = 3'd0;
    localparam logic [2:0] C_OR   = 3'd1;
    localparam logic [2:0] C_ADD  = 3'd2;
    localparam logic [2:0] C_SUB  = 3'd3;
    localparam logic [2:0] C_ADDC = 3'd4;
    localparam logic [2:0] C_SUBC = 3'd5;
    localparam logic [2:0] C_CMP  = 3'd6;
    localparam logic [2:0] C_OP7  = 3'd7;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   CS;
    logic [W-1:0] data_a;
    logic [W-1:0] data_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] S;
    logic [W-1:0] S_hi;
    logic         zero;
    logic         carry_out;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int unsigned m_s;
    int unsigned m_hi;
    bit          m_z;
    bit          m_c;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .CS        (CS),
        .data_a    (data_a),
        .data_b    (data_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .S_hi      (S_hi),
        .zero      (zero),
        .carry_out (carry_out)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag);
        check({tag, ".S"},     32'(S),         m_s);
        check({tag, ".S_hi"},  32'(S_hi),      m_hi);
        check({tag, ".zero"},  32'(zero),      32'(m_z));
        check({tag, ".carry"}, 32'(carry_out), 32'(m_c));
    endtask

    task automatic model_reset();
        m_s  = 0;
        m_hi = 0;
        m_z  = 1'b1;
        m_c  = 1'b0;
    endtask

    task automatic ref_apply(input logic [2:0] op, input int unsigned a, input int unsigned b);
        int unsigned t;
        int unsigned bin;
        longint unsigned p;
        m_hi = 0;
        case (op)
            C_AND: m_s = a & b;
            C_OR:  m_s = a | b;
            C_ADD: begin
                t   = a + b;
                m_s = t % LIM;
                m_c = (t >= LIM);
            end
            C_ADDC: begin
                t   = a + b + (m_c ? 1 : 0);
                m_s = t % LIM;
                m_c = (t >= LIM);
            end
            C_SUB: begin
                m_s = (a + LIM - b) % LIM;
                m_c = (a >= b);
            end
            C_SUBC: begin
                bin = m_c ? 0 : 1;
                m_s = (a + 2 * LIM - b - bin) % LIM;
                m_c = (a >= b + bin);
            end
            C_CMP: m_s = (a < b) ? 1 : 0;
            default: begin
`ifdef ALU_MUL_EN
                p    = longint'(a) * longint'(b);
                m_s  = int'(p % longint'(LIM));
                m_hi = int'(p / longint'(LIM));
                m_c  = (m_hi != 0);
`else
                p    = 0;
                m_s  = a;
`endif
            end
        endcase
        m_z = (m_s == 0) && (m_hi == 0);
    endtask

    // Issue one op with out_ready high and check its result at the expected cycle.
    task automatic issue(input string tag, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bit old_c;
        bit old_z;
        @(negedge clk);
        CS        = op;
        data_a    = a;
        data_b    = b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        old_c = m_c;
        old_z = m_z;
        ref_apply(op, 32'(a), 32'(b));
`ifdef ALU_MUL_EN
        if (op == C_OP7) begin
            for (int k = 0; k < W; k++) begin
                check({tag, ".busy_out_valid"}, 32'(out_valid), 32'd0);
                check({tag, ".busy_in_ready"},  32'(in_ready),  32'd0);
                check({tag, ".busy_carry"},     32'(carry_out), 32'(old_c));
                check({tag, ".busy_zero"},      32'(zero),      32'(old_z));
                @(posedge clk);
                #1;
            end
        end
`endif
        check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        check_outs(tag);
    endtask

    initial begin
        logic [2:0]   rop;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        CS        = 3'd0;
        data_a    = '0;
        data_b    = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.in_ready",  32'(in_ready),  32'd1);
        check_outs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        issue("add", C_ADD, 8'hF0, 8'h20);
        check("add.S_lit", 32'(S), 32'h10);
        check("add.carry_lit", 32'(carry_out), 32'd1);
        issue("addc", C_ADDC, 8'h01, 8'h01);
        check("addc.S_lit", 32'(S), 32'h03);
        issue("sub", C_SUB, 8'h05, 8'h07);
        check("sub.S_lit", 32'(S), 32'hFE);
        issue("subc", C_SUBC, 8'h10, 8'h01);
        check("subc.S_lit", 32'(S), 32'h0E);
        issue("sub_eq", C_SUB, 8'h33, 8'h33);
        check("sub_eq.zero_lit", 32'(zero), 32'd1);
        issue("cmp", C_CMP, 8'h02, 8'h03);
        check("cmp.carry_lit", 32'(carry_out), 32'd1);
        issue("and", C_AND, 8'hAA, 8'h55);
        issue("or", C_OR, 8'hA0, 8'h05);
`ifdef ALU_MUL_EN
        issue("mul_ff", C_OP7, 8'hFF, 8'hFF);
        check("mul_ff.S_hi_lit", 32'(S_hi), 32'hFE);
        issue("mul_zero", C_OP7, 8'h00, 8'h7F);
`else
        issue("pass", C_OP7, 8'h5A, 8'h11);
        check("pass.S_lit", 32'(S), 32'h5A);
`endif

        // Result taken with no new request: unit empties, outputs hold.
        @(posedge clk);
        #1;
        check("take.out_valid", 32'(out_valid), 32'd0);
        check_outs("take");

        // Backpressure: result held while a new request waits.
        @(negedge clk);
        CS        = C_ADD;
        data_a    = 8'h7F;
        data_b    = 8'h01;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        ref_apply(C_ADD, 32'h7F, 32'h01);
        CS     = C_SUB;
        data_a = 8'h40;
        data_b = 8'h10;
        for (int k = 0; k < 3; k++) begin
            check("bp.out_valid", 32'(out_valid), 32'd1);
            check("bp.in_ready",  32'(in_ready),  32'd0);
            check_outs("bp");
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("bp.release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ref_apply(C_SUB, 32'h40, 32'h10);
        check("bp.next_out_valid", 32'(out_valid), 32'd1);
        check_outs("bp.next");

        for (int i = 0; i < 200; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = W'($urandom);
            rb  = W'($urandom);
            if (i % 16 == 0) rb = ra;
            issue("rand", rop, ra, rb);
        end

        // Reset in the middle of work discards it.
        @(negedge clk);
        CS        = C_OP7;
        data_a    = 8'hC3;
        data_b    = 8'h5D;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.in_ready",  32'(in_ready),  32'd1);
        check_outs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst.idle_out_valid", 32'(out_valid), 32'd0);
        issue("post_rst", C_ADDC, 8'h01, 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
